// File: rtl/riscv_pkg.sv
// Shared constants and types for the integer register file and writeback stage.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/writeback_stage_reg_file.sv
// Integer register file: two combinational read ports, one synchronous write port.
// x0 always reads as zero. Build with WB_BYPASS_EN defined to forward a
// same-cycle write to a matching read port; otherwise reads see the array only.
module reg_file
    import riscv_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_we,
    input  reg_idx_t i_waddr,
    input  xlen_t    i_wdata,
    input  reg_idx_t i_rs1,
    input  reg_idx_t i_rs2,
    output xlen_t    o_rs1_data,
    output xlen_t    o_rs2_data
);

    xlen_t regs_q [NUM_REGS];
    xlen_t regs_d [NUM_REGS];

    // Next array contents: copy, then apply the qualified write (never to x0).
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (i_we && (i_waddr != REG_ZERO)) begin
            regs_d[i_waddr] = i_wdata;
        end
    end

    // Array storage with synchronous clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    function automatic xlen_t read_port(input reg_idx_t idx);
        xlen_t val;
        val = regs_q[idx];
`ifdef WB_BYPASS_EN
        if (i_we && (i_waddr == idx)) begin
            val = i_wdata;
        end
`endif
        if (idx == REG_ZERO) begin
            val = '0;
        end
        return val;
    endfunction

    // Combinational read ports with x0 masking.
    always_comb begin
        o_rs1_data = read_port(i_rs1);
        o_rs2_data = read_port(i_rs2);
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: qualifies commits from the memory-access stage, writes the
// register file, keeps a registered forwarding copy and a retired-write count.
// Optional macro WB_BYPASS_EN enables write-through bypass in the register file.
module writeback_stage
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       i_data,
    input  logic                  i_write_to_reg,
    input  logic [REG_ADDR_W-1:0] i_dst_reg,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic [XLEN-1:0]       o_rs1_data,
    output logic [XLEN-1:0]       o_rs2_data,
    output logic                  o_wb_valid,
    output logic [REG_ADDR_W-1:0] o_wb_reg,
    output logic [XLEN-1:0]       o_wb_data,
    output logic [31:0]           o_retire_count
);

    logic     commit;
    logic     wb_valid_q, wb_valid_d;
    reg_idx_t wb_reg_q, wb_reg_d;
    xlen_t    wb_data_q, wb_data_d;
    logic [31:0] retire_count_q, retire_count_d;

    // Writes to x0 are dropped entirely: no forwarding, no count.
    always_comb begin
        commit = i_write_to_reg && (i_dst_reg != REG_ZERO);
    end

    reg_file u_reg_file (
        .clk        (clk),
        .rst        (rst),
        .i_we       (commit),
        .i_waddr    (i_dst_reg),
        .i_wdata    (i_data),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .o_rs1_data (o_rs1_data),
        .o_rs2_data (o_rs2_data)
    );

    // Next forwarding copy and retire count; counter wraps silently.
    always_comb begin
        wb_valid_d     = commit;
        wb_reg_d       = commit ? i_dst_reg : REG_ZERO;
        wb_data_d      = commit ? i_data : '0;
        retire_count_d = retire_count_q + {31'd0, commit};
    end

    // Forwarding and counter registers; reset overrides any concurrent commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q     <= 1'b0;
            wb_reg_q       <= '0;
            wb_data_q      <= '0;
            retire_count_q <= '0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_reg_q       <= wb_reg_d;
            wb_data_q      <= wb_data_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign o_wb_valid     = wb_valid_q;
    assign o_wb_reg       = wb_reg_q;
    assign o_wb_data      = wb_data_q;
    assign o_retire_count = retire_count_q;

endmodule
